// File: rtl/pid_ahb_pkg.sv
// Shared AHB-Lite encodings, PID register offsets, command layout and FSM states.
package pid_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // PID slave register map (byte offsets from the slave base)
   localparam logic [15:0] OFF_INITN  = 16'h0000;
   localparam logic [15:0] OFF_COEFF0 = 16'h0004;
   localparam logic [15:0] OFF_COEFF1 = 16'h0008;
   localparam logic [15:0] OFF_COEFF2 = 16'h000C;
   localparam logic [15:0] OFF_COEFF3 = 16'h0010;
   localparam logic [15:0] OFF_COEFF4 = 16'h0014;
   localparam logic [15:0] OFF_COEFF5 = 16'h0018;
   localparam logic [15:0] OFF_DIN0   = 16'h001C;
   localparam logic [15:0] OFF_DIN1   = 16'h0020;

   // One queued bus command: 16 + 32 + 1 = 49 bits
   typedef struct packed {
      logic [15:0] offset;
      logic [31:0] wdata;
      logic        write;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // no data phase on the bus
      ST_XFER = 2'b01,   // a data phase is in progress
      ST_ERR  = 2'b10    // between ERROR cycle 1 and cycle 2
   } state_t;

   function automatic logic resp_is_error(input logic [1:0] resp);
      return resp == HRESP_ERROR;
   endfunction

endpackage

// File: rtl/pid_cmd_fifo.sv
// Command FIFO: small synchronous FIFO with extra-bit pointers and a
// combinational head so the command can drive the address phase directly.
module pid_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 49
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage write; contents need no reset because the pointers gate them
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

   // Pointer advance, wrapping naturally through the extra MSB
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/pid_ahb_master.sv
// AHB-Lite single-transfer initiator for the PID accelerator register map.
// Commands queue in a FIFO, issue as pipelined NONSEQ/SINGLE word transfers,
// and each returns exactly one response; an ERROR parks any pipelined command
// in a retry slot that is reissued ahead of the FIFO.
module pid_ahb_master
   import pid_ahb_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_offset,
   input  logic [31:0] cmd_wdata,
   input  logic        cmd_write,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [31:0] ex_i_ahb_AHB_Master_PID_haddr,
   output logic [1:0]  ex_i_ahb_AHB_Master_PID_htrans,
   output logic        ex_i_ahb_AHB_Master_PID_hwrite,
   output logic [2:0]  ex_i_ahb_AHB_Master_PID_hsize,
   output logic [2:0]  ex_i_ahb_AHB_Master_PID_hburst,
   output logic [31:0] ex_i_ahb_AHB_Master_PID_hwdata,
   input  logic [31:0] ex_i_ahb_AHB_Master_PID_hrdata,
   input  logic        ex_i_ahb_AHB_Master_PID_hready,
   input  logic [1:0]  ex_i_ahb_AHB_Master_PID_hresp
);

   cmd_t        push_cmd, fifo_head, issue_cmd;
   cmd_t        retry_q, retry_d;
   logic        retry_vld_q, retry_vld_d;
   state_t      state_q, state_d;
   logic        dp_write_q, dp_write_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic        hready, resp_err, err_cycle1, issue, accept, data_done;

   assign hready    = ex_i_ahb_AHB_Master_PID_hready;
   assign resp_err  = resp_is_error(ex_i_ahb_AHB_Master_PID_hresp);
   assign push_cmd  = {cmd_offset, cmd_wdata, cmd_write};
   assign fifo_push = cmd_valid && cmd_ready;

   pid_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(cmd_t))
   ) u_fifo (
      .clk_i   (HCLK),
      .rst_i   (HRESETn),
      .push_i  (fifo_push),
      .data_i  (push_cmd),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Address-phase issue, FSM next state, retry slot and response capture
   always_comb begin
      err_cycle1  = (state_q == ST_XFER) && !hready && resp_err;
      issue       = (retry_vld_q || !fifo_empty) && (state_q != ST_ERR) && !err_cycle1;
      issue_cmd   = retry_vld_q ? retry_q : fifo_head;
      accept      = issue && hready;
      data_done   = (state_q != ST_IDLE) && hready;
      // The head leaves the FIFO either when accepted or when it is parked in retry
      fifo_pop    = !retry_vld_q && (accept || (err_cycle1 && !fifo_empty));

      retry_d     = retry_q;
      retry_vld_d = retry_vld_q;
      if (err_cycle1 && !retry_vld_q && !fifo_empty) begin
         retry_d     = fifo_head;
         retry_vld_d = 1'b1;
      end else if (accept && retry_vld_q) begin
         retry_vld_d = 1'b0;
      end

      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_XFER;
         ST_XFER: begin
            if (err_cycle1)  state_d = ST_ERR;
            else if (hready) state_d = accept ? ST_XFER : ST_IDLE;
         end
         ST_ERR:  if (hready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      dp_write_d = accept ? issue_cmd.write : dp_write_q;
      hwdata_d   = hwdata_q;
      if (accept) hwdata_d = issue_cmd.write ? issue_cmd.wdata : 32'd0;

      rsp_valid_d = data_done;
      rsp_err_d   = data_done && resp_err;
      rsp_rdata_d = (data_done && !dp_write_q && !resp_err) ?
                    ex_i_ahb_AHB_Master_PID_hrdata : 32'd0;
   end

   // State, data-phase and response registers
   always_ff @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         state_q     <= ST_IDLE;
         retry_q     <= '0;
         retry_vld_q <= 1'b0;
         dp_write_q  <= 1'b0;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         retry_vld_q <= retry_vld_d;
         dp_write_q  <= dp_write_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign ex_i_ahb_AHB_Master_PID_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ex_i_ahb_AHB_Master_PID_haddr  = issue ? {BASE_ADDR[31:16], issue_cmd.offset} : 32'd0;
   assign ex_i_ahb_AHB_Master_PID_hwrite = issue && issue_cmd.write;
   assign ex_i_ahb_AHB_Master_PID_hsize  = HSIZE_WORD;
   assign ex_i_ahb_AHB_Master_PID_hburst = HBURST_SINGLE;
   assign ex_i_ahb_AHB_Master_PID_hwdata = hwdata_q;

   assign cmd_ready = !fifo_full;
   assign busy      = !fifo_empty || retry_vld_q || (state_q != ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_pid_ahb_master.sv
// Bench for pid_ahb_master: behavioural AHB slave with per-offset wait and
// error injection, response scoreboard, and directed bus-timing checks.
module tb_pid_ahb_master;
   import pid_ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_offset = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_write = 1'b0;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans, hresp;
   logic        hwrite, hready;
   logic [2:0]  hsize, hburst;

   always #5 HCLK = ~HCLK;

   pid_ahb_master dut (
      .HCLK                           (HCLK),
      .HRESETn                        (HRESETn),
      .cmd_valid                      (cmd_valid),
      .cmd_ready                      (cmd_ready),
      .cmd_offset                     (cmd_offset),
      .cmd_wdata                      (cmd_wdata),
      .cmd_write                      (cmd_write),
      .rsp_valid                      (rsp_valid),
      .rsp_rdata                      (rsp_rdata),
      .rsp_err                        (rsp_err),
      .busy                           (busy),
      .ex_i_ahb_AHB_Master_PID_haddr  (haddr),
      .ex_i_ahb_AHB_Master_PID_htrans (htrans),
      .ex_i_ahb_AHB_Master_PID_hwrite (hwrite),
      .ex_i_ahb_AHB_Master_PID_hsize  (hsize),
      .ex_i_ahb_AHB_Master_PID_hburst (hburst),
      .ex_i_ahb_AHB_Master_PID_hwdata (hwdata),
      .ex_i_ahb_AHB_Master_PID_hrdata (hrdata),
      .ex_i_ahb_AHB_Master_PID_hready (hready),
      .ex_i_ahb_AHB_Master_PID_hresp  (hresp)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_rsp    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rd_val(input logic [15:0] off);
      return 32'hC0DE_0000 | {16'h0000, off};
   endfunction

   // ---------------- behavioural slave ----------------
   int          wait_off = -1;
   int          wait_n   = 0;
   int          err_off  = -1;
   logic        s_dp_valid, s_dp_write;
   logic [15:0] s_dp_off;
   int          s_wait, s_err;

   assign hready = !s_dp_valid || (s_wait == 0 && s_err != 1);
   assign hresp  = (s_dp_valid && s_wait == 0 && s_err != 0) ? 2'b01 : 2'b00;
   assign hrdata = (s_dp_valid && !s_dp_write && s_wait == 0 && s_err == 0) ?
                   rd_val(s_dp_off) : 32'hBAD0_BAD0;

   always @(posedge HCLK or posedge HRESETn) begin
      if (HRESETn) begin
         s_dp_valid <= 1'b0; s_dp_write <= 1'b0; s_dp_off <= '0;
         s_wait <= 0; s_err <= 0;
      end else if (hready) begin
         if (htrans == HTRANS_NONSEQ) begin
            s_dp_valid <= 1'b1;
            s_dp_write <= hwrite;
            s_dp_off   <= haddr[15:0];
            s_wait     <= (int'(haddr[15:0]) == wait_off) ? wait_n : 0;
            s_err      <= (int'(haddr[15:0]) == err_off) ? 1 : 0;
         end else begin
            s_dp_valid <= 1'b0; s_wait <= 0; s_err <= 0;
         end
      end else if (s_wait > 0) begin
         s_wait <= s_wait - 1;
      end else if (s_err == 1) begin
         s_err <= 2;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [15:0] off;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] wexp [logic [15:0]];

   // Response and write-data monitor, sampled mid-cycle
   always @(negedge HCLK) begin
      exp_t e;
      if (!HRESETn) begin
         if (rsp_valid) begin
            n_rsp++;
            $display("rsp %0d: rdata=%h err=%0d", n_rsp, rsp_rdata, rsp_err);
            check("rsp_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", rsp_err, e.err);
            end
         end
         if (s_dp_valid && s_dp_write && hready && hresp == HRESP_OKAY) begin
            check("wr_off_known", wexp.exists(s_dp_off), 1);
            if (wexp.exists(s_dp_off)) check("hwdata", hwdata, wexp[s_dp_off]);
         end
      end
   end

   task automatic send(input logic [15:0] off, input logic [31:0] wd,
                       input logic wr, input logic err);
      exp_t e;
      int   cnt = 0;
      cmd_valid = 1'b1; cmd_offset = off; cmd_wdata = wd; cmd_write = wr;
      while (!cmd_ready && cnt < 200) begin
         @(negedge HCLK);
         cnt++;
      end
      if (cnt >= 200) check("send_timeout", cmd_ready, 1);
      e.off   = off;
      e.rdata = (wr || err) ? 32'd0 : rd_val(off);
      e.err   = err;
      sb.push_back(e);
      if (wr) wexp[off] = wd;
      $display("cmd off=%h wr=%0d wdata=%h", off, wr, wd);
      @(negedge HCLK);
   endtask

   task automatic drain();
      int cnt = 0;
      while ((sb.size() != 0 || busy) && cnt < 300) begin
         @(negedge HCLK);
         cnt++;
      end
      @(negedge HCLK);
      check("drain_sb", sb.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rec;
      // ---- reset values (asynchronous, before any clock edge matters) ----
      #2;
      check("rst_htrans", htrans, HTRANS_IDLE);
      check("rst_haddr", haddr, 0);
      check("rst_hwrite", hwrite, 0);
      check("rst_hwdata", hwdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_busy", busy, 0);
      check("hsize", hsize, 3'b010);
      check("hburst", hburst, 3'b000);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b0;
      @(negedge HCLK);
      check("rst_cmd_ready", cmd_ready, 1);

      // ---- 1: single write, zero-wait latency ----
      send(OFF_DIN0, 32'h0012345, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      check("t1_addr_htrans", htrans, HTRANS_NONSEQ);
      check("t1_haddr", haddr, 32'h4000_001C);
      check("t1_hwrite", hwrite, 1);
      @(negedge HCLK);
      check("t1_hwdata", hwdata, 32'h0012345);
      check("t1_rsp_early", rsp_valid, 0);
      @(negedge HCLK);
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_rsp_err", rsp_err, 0);
      drain();

      // ---- 2: seven back-to-back writes ----
      rec = n_rsp;
      fork
         begin
            for (int i = 0; i < 7; i++)
               send(16'(4 * i), (i == 0) ? 32'd1 : 32'(32'h100 + i), 1'b1, 1'b0);
            cmd_valid = 1'b0;
         end
         begin
            int cnt = 0;
            while (htrans != HTRANS_NONSEQ && cnt < 50) begin
               @(negedge HCLK);
               cnt++;
            end
            for (int i = 0; i < 7; i++) begin
               check($sformatf("t2_htrans%0d", i), htrans, HTRANS_NONSEQ);
               check($sformatf("t2_haddr%0d", i), haddr, 32'h4000_0000 + 32'(4 * i));
               @(negedge HCLK);
            end
            check("t2_idle_after", htrans, HTRANS_IDLE);
         end
      join
      drain();
      check("t2_rsp_count", n_rsp - rec, 7);

      // ---- 3a: waited read with a pipelined write held in address phase ----
      wait_off = int'(OFF_COEFF2); wait_n = 2;
      send(OFF_COEFF2, 32'd0, 1'b0, 1'b0);
      send(OFF_DIN1, 32'hA5A5_0001, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t3_hold_haddr%0d", i), haddr, 32'h4000_0020);
         check($sformatf("t3_hold_htrans%0d", i), htrans, HTRANS_NONSEQ);
         @(negedge HCLK);
      end
      drain();
      // ---- 3b: waited write keeps hwdata stable ----
      wait_off = int'(OFF_COEFF1); wait_n = 2;
      send(OFF_COEFF1, 32'hDEAD_BEEF, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         check($sformatf("t3_hwdata_hold%0d", i), hwdata, 32'hDEAD_BEEF);
      end
      drain();
      wait_off = -1;

      // ---- 4: ERROR on COEFF3 with COEFF4 pipelined ----
      err_off = int'(OFF_COEFF3);
      send(OFF_COEFF3, 32'h0000_3333, 1'b1, 1'b1);
      send(OFF_COEFF4, 32'h0000_4444, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      check("t4_err1_idle", htrans, HTRANS_IDLE);
      @(negedge HCLK);
      check("t4_err2_idle", htrans, HTRANS_IDLE);
      @(negedge HCLK);
      check("t4_reissue_htrans", htrans, HTRANS_NONSEQ);
      check("t4_reissue_haddr", haddr, 32'h4000_0014);
      drain();
      err_off = -1;

      // ---- 5: fill the FIFO behind a long-stalled transfer ----
      wait_off = int'(OFF_INITN); wait_n = 12;
      send(OFF_INITN, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) check("t5_ready_before4", cmd_ready, 1);
         send(16'(OFF_COEFF0 + 16'(4 * i)), 32'(32'h5000 + i), 1'b1, 1'b0);
      end
      cmd_offset = OFF_DIN1; cmd_wdata = 32'h0; cmd_write = 1'b0;
      check("t5_full_ready0", cmd_ready, 0);
      @(negedge HCLK);
      check("t5_held_ready0", cmd_ready, 0);
      @(negedge HCLK);
      check("t5_still_held", cmd_ready, 0);
      send(OFF_DIN1, 32'h0, 1'b0, 1'b0);
      cmd_valid = 1'b0;
      drain();
      wait_off = -1;

      // ---- 6: reset during a stalled data phase ----
      wait_off = int'(OFF_DIN0); wait_n = 6;
      send(OFF_DIN0, 32'h0000_0055, 1'b1, 1'b0);
      send(OFF_DIN1, 32'h0000_0066, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      check("t6_htrans_async", htrans, HTRANS_IDLE);
      check("t6_busy", busy, 0);
      check("t6_haddr", haddr, 0);
      check("t6_hwdata", hwdata, 0);
      sb.delete();
      wait_off = -1;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b0;
      rec = n_rsp;
      repeat (10) @(negedge HCLK);
      check("t6_no_rsp", n_rsp - rec, 0);
      check("t6_ready", cmd_ready, 1);
      send(OFF_DIN1, 32'h0000_0777, 1'b1, 1'b0);
      cmd_valid = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
